serial_panel_tx: RTL and testbench
==================================

Name: serial_panel_tx

Overview:
- Transmit end of the clock+data serial links that feed the reduced machine's typewriter row (TPR_CLK/TPR_DATA) and staticisor switches (S_CLK/S_DATA).
- Latches a parallel frame, e.g. panel switch states, and shifts it out bit 0 first as a gated serial clock plus data line.
- The far-end receiver writes bit i on the i-th SER_CLK rising edge and wraps after FRAME_LENGTH edges.
- One instance per link; FRAME_LENGTH=40 for TPR, 20 for S.

Parameters:
- FRAME_LENGTH, 40, bits per frame; must equal the receiver's line/word length.
- DIV, 4, CLK cycles per SER_CLK half-period; legal range is 1 or more.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RST_N  in  1  asynchronous, active-low reset.
- DATA_IN  in  FRAME_LENGTH  parallel frame; sampled only on the load cycle.
- START  in  1  request one frame; sampled in IDLE.
- AUTO  in  1  continuous refresh; sampled on the last cycle of a frame.
- BUSY  out  1  high while a frame is in flight.
- DONE  out  1  one-cycle pulse when a frame completes.
- SER_CLK  out  1  serial clock to the receiver.
- SER_DATA  out  1  serial data to the receiver.

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE, shift register 0, bit counter 0, phase counter 0.
  - BUSY=0, DONE=0, SER_CLK=0, SER_DATA=0.
- States:
  - IDLE, LOW (SER_CLK=0, DIV cycles), HIGH (SER_CLK=1, DIV cycles).
  - Registered outputs: SER_CLK=1 exactly when state is HIGH; BUSY=1 exactly when state is LOW or HIGH.
- IDLE with START=1 at posedge:
  - Load DATA_IN into the shift register and clear the bit counter.
  - Enter LOW. SER_DATA=DATA_IN[0] from the next cycle.
- LOW to HIGH after DIV cycles.
  - SER_DATA is held constant through the whole LOW+HIGH pair, giving DIV cycles of setup and DIV cycles of hold around the rising edge.
- HIGH, after DIV cycles, bit counter < FRAME_LENGTH-1:
  - Increment the bit counter and shift right.
  - Enter LOW with SER_DATA = next bit.
  - SER_DATA changes only on the same edge that SER_CLK falls.
- HIGH, after DIV cycles, bit counter = FRAME_LENGTH-1 (frame end):
  - DONE=1 for exactly one cycle, coincident with SER_CLK returning to 0.
  - AUTO=1 at that edge: re-latch DATA_IN, enter LOW, BUSY stays 1, SER_DATA=new bit 0.
  - AUTO=0: enter IDLE, BUSY=0, SER_DATA=0.
- Timing:
  - Each frame is exactly FRAME_LENGTH rising edges and 2*DIV*FRAME_LENGTH cycles, from the first LOW cycle to the DONE cycle exclusive.
  - START-to-first-rise latency is DIV+1 cycles.
- START is ignored while BUSY, including in the DONE cycle, which is governed by AUTO only. DATA_IN changes mid-frame have no effect.
- Bit counter width is clog2(FRAME_LENGTH) bits, minimum 1. Phase counter width is clog2(DIV) bits, minimum 1. Neither counter ever exceeds its terminal value.
- Reset mid-frame:
  - Outputs drop immediately.
  - The receiver has no reset and is left misaligned by the number of edges already sent.
  - Recovery is system-level: reset both ends together, or the host sends FRAME_LENGTH minus the edges already sent as padding.
  - The block itself issues no partial frame after reset.

Decomposition:
- Shared package serial_link_pkg:
  - State enum {IDLE, LOW, HIGH}.
  - Default constants TPR_FRAME=40, S_FRAME=20, SER_DIV=4, so the RX and TX ends agree.
- One natural sub-module, serial_phase_timer:
  - Counts DIV cycles.
  - Emits a one-cycle phase_end; clears on load.
- Shift register, bit counter and FSM stay in the top module.

Test Plan:
- All tests use FRAME_LENGTH=4, DIV=2 unless stated.
- Single frame: DATA_IN=4'b1011, START pulse -> SER_CLK shows 4 rises, 4 cycles apart. SER_DATA at each rise is 1,1,0,1. DONE pulses once, 16 cycles after the first LOW cycle. BUSY then falls to 0.
- Loopback: TX with FRAME_LENGTH=20, DIV=1 into a model of the staticisor receiver, DATA_IN=20'hA5C3E -> receiver register equals 20'hA5C3E after DONE. Repeat with FRAME_LENGTH=40.
- AUTO refresh: AUTO=1; DATA_IN=4'hF for frame 1, changed to 4'h0 mid-frame -> frame 1 bits are all 1 and frame 2 bits are all 0. SER_CLK low phase is continuous across the boundary and BUSY never drops.
- START while BUSY: START held high for 30 cycles -> exactly 2 back-to-back frames are not produced. Instead, one frame is sent, then a new frame starts on the first IDLE cycle after DONE.
- Reset mid-frame: assert RST_N=0 during the HIGH phase of bit 2 -> SER_CLK, SER_DATA, BUSY and DONE go to 0 asynchronously. After release, no edges appear until START.
- DIV=1 corner: SER_CLK toggles every cycle. SER_DATA is never changed on the same edge that SER_CLK rises.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for the panel serial links.
// Both link ends take their default frame sizes and divider from here.
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH
  } link_state_e;

  localparam int TPR_FRAME = 40;
  localparam int S_FRAME   = 20;
  localparam int SER_DIV   = 4;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_panel_tx_if.sv
// Host-facing bundle of the panel serial transmitter.
// The master side supplies the frame; the slave side drives the link.
interface serial_panel_tx_if
  import serial_link_pkg::*;
#(
  parameter int FRAME_LENGTH = TPR_FRAME
) ();

  logic [FRAME_LENGTH-1:0] DATA_IN;
  logic                    START;
  logic                    AUTO;
  logic                    BUSY;
  logic                    DONE;
  logic                    SER_CLK;
  logic                    SER_DATA;

  modport master (
    output DATA_IN,
    output START,
    output AUTO,
    input  BUSY,
    input  DONE,
    input  SER_CLK,
    input  SER_DATA
  );

  modport slave (
    input  DATA_IN,
    input  START,
    input  AUTO,
    output BUSY,
    output DONE,
    output SER_CLK,
    output SER_DATA
  );

endinterface

// File: rtl/serial_phase_timer.sv
// Counts DIV cycles of one serial clock half-period.
// phase_end marks the last cycle of each half-period.
module serial_phase_timer
  import serial_link_pkg::*;
#(
  parameter int DIV = SER_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_phase_end
);

  localparam int            CW   = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_phase_end = i_en & w_last;

endmodule

// File: rtl/serial_panel_tx.sv
// Panel serial transmitter: shifts a latched frame out LSB first
// as a gated serial clock plus data line.
module serial_panel_tx
  import serial_link_pkg::*;
#(
  parameter int FRAME_LENGTH = TPR_FRAME,
  parameter int DIV          = SER_DIV
) (
  input  logic              CLK,
  input  logic              RST_N,
  serial_panel_tx_if.slave  bus
);

  localparam int            BW       = cnt_w(FRAME_LENGTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_LENGTH - 1);

  link_state_e             r_state;
  link_state_e             w_next;
  logic [FRAME_LENGTH-1:0] r_shift;
  logic [BW-1:0]           r_bit;
  logic                    r_done;

  logic w_active;
  logic w_phase_end;
  logic w_last_bit;
  logic w_end;
  logic w_shift;
  logic w_load;

  assign w_active   = (r_state != IDLE);
  assign w_last_bit = (r_bit == LAST_BIT);
  assign w_end      = (r_state == HIGH) && w_phase_end && w_last_bit;
  assign w_shift    = (r_state == HIGH) && w_phase_end && !w_last_bit;
  assign w_load     = ((r_state == IDLE) && bus.START) ||
                      (w_end && bus.AUTO);

  serial_phase_timer #(
    .DIV (DIV)
  ) u_timer (
    .i_clk       (CLK),
    .i_rst_n     (RST_N),
    .i_en        (w_active),
    .i_clr       (w_load),
    .o_phase_end (w_phase_end)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (bus.START) w_next = LOW;
      LOW:  if (w_phase_end) w_next = HIGH;
      HIGH: begin
        if (w_phase_end) begin
          if (!w_last_bit || bus.AUTO) w_next = LOW;
          else                         w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Data only moves when HIGH ends, i.e. on the falling serial edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_shift <= '0;
      r_bit   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_end;
      if (w_load) begin
        r_shift <= bus.DATA_IN;
        r_bit   <= '0;
      end else if (w_shift) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + 1'b1;
      end else if (w_end) begin
        r_shift <= '0;
        r_bit   <= '0;
      end
    end
  end

  always_comb begin
    bus.BUSY     = w_active;
    bus.SER_CLK  = (r_state == HIGH);
    bus.SER_DATA = r_shift[0];
    bus.DONE     = r_done;
  end

endmodule

// File: tb/tb_serial_panel_tx.sv
// Bench for serial_panel_tx: expected serial bits are queued at stimulus
// time and matched on every observed serial clock rise.
module tb_serial_panel_tx;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_panel_tx_if #(.FRAME_LENGTH(4))  if_a ();
  serial_panel_tx_if #(.FRAME_LENGTH(20)) if_l20 ();
  serial_panel_tx_if #(.FRAME_LENGTH(40)) if_l40 ();
  serial_panel_tx_if #(.FRAME_LENGTH(4))  if_d ();

  serial_panel_tx #(.FRAME_LENGTH(4), .DIV(2)) u_a (
    .CLK(clk), .RST_N(rst_n), .bus(if_a));
  serial_panel_tx #(.FRAME_LENGTH(20), .DIV(1)) u_l20 (
    .CLK(clk), .RST_N(rst_n), .bus(if_l20));
  serial_panel_tx #(.FRAME_LENGTH(40), .DIV(1)) u_l40 (
    .CLK(clk), .RST_N(rst_n), .bus(if_l40));
  serial_panel_tx #(.FRAME_LENGTH(4), .DIV(1)) u_d (
    .CLK(clk), .RST_N(rst_n), .bus(if_d));

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic done_of(input int s);
    case (s)
      0:       return if_a.DONE;
      1:       return if_l20.DONE;
      2:       return if_l40.DONE;
      default: return if_d.DONE;
    endcase
  endfunction

  task automatic wait_done(input int s, input int max, output int t);
    bit seen;
    seen = 0;
    t = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (done_of(s)) begin
        seen = 1;
        t = cyc;
      end
    end
    chk($sformatf("done_timeout%0d", s), 64'(seen), 64'd1);
  endtask

  // Scoreboard and rise monitor for instance A
  logic a_q[$];
  int   a_rises, a_extra, a_last_rise, a_first_rise;
  logic a_pclk;
  initial begin
    a_rises = 0; a_extra = 0; a_last_rise = -1;
    a_first_rise = 0; a_pclk = 0;
    forever begin
      @(negedge clk);
      if (if_a.SER_CLK && !a_pclk) begin
        a_rises++;
        if (a_q.size() == 0) a_extra++;
        else chk("a_bit", 64'(if_a.SER_DATA), 64'(a_q.pop_front()));
        if (a_last_rise >= 0) chk("a_rise_gap", 64'(cyc - a_last_rise), 64'd4);
        else a_first_rise = cyc;
        a_last_rise = cyc;
      end
      if (!if_a.BUSY) a_last_rise = -1;
      a_pclk = if_a.SER_CLK;
    end
  end

  // DIV=1 instance: bits, toggle rate and data stability at rises
  logic d_q[$];
  int   d_rises, d_extra, d_stab_viol, d_tog_viol;
  logic d_pclk, d_pdata, d_pbusy;
  initial begin
    d_rises = 0; d_extra = 0; d_stab_viol = 0; d_tog_viol = 0;
    d_pclk = 0; d_pdata = 0; d_pbusy = 0;
    forever begin
      @(negedge clk);
      if (if_d.SER_CLK && !d_pclk) begin
        d_rises++;
        if (if_d.SER_DATA !== d_pdata) d_stab_viol++;
        if (d_q.size() == 0) d_extra++;
        else chk("d_bit", 64'(if_d.SER_DATA), 64'(d_q.pop_front()));
      end
      if (if_d.BUSY && d_pbusy && (if_d.SER_CLK == d_pclk)) d_tog_viol++;
      d_pclk = if_d.SER_CLK;
      d_pdata = if_d.SER_DATA;
      d_pbusy = if_d.BUSY;
    end
  end

  // Far-end receiver models: write bit i on rise i, wrap per frame
  logic [19:0] rx20;
  logic [39:0] rx40;
  int          rx20_i, rx40_i;
  initial begin
    rx20 = '0; rx20_i = 0;
    forever begin
      @(posedge if_l20.SER_CLK);
      rx20[rx20_i] = if_l20.SER_DATA;
      rx20_i = (rx20_i == 19) ? 0 : rx20_i + 1;
    end
  end
  initial begin
    rx40 = '0; rx40_i = 0;
    forever begin
      @(posedge if_l40.SER_CLK);
      rx40[rx40_i] = if_l40.SER_DATA;
      rx40_i = (rx40_i == 39) ? 0 : rx40_i + 1;
    end
  end

  task automatic push_a(input logic [3:0] v);
    for (int i = 0; i < 4; i++) a_q.push_back(v[i]);
  endtask

  initial begin
    int   t0, t1, k, nd, drop, nr, snap;
    logic pd, pc;
    logic [19:0] v20;
    logic [39:0] v40;

    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    if_a.DATA_IN = '0;   if_a.START = 0;   if_a.AUTO = 0;
    if_l20.DATA_IN = '0; if_l20.START = 0; if_l20.AUTO = 0;
    if_l40.DATA_IN = '0; if_l40.START = 0; if_l40.AUTO = 0;
    if_d.DATA_IN = '0;   if_d.START = 0;   if_d.AUTO = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(if_a.BUSY), 64'd0);
    chk("rst_done", 64'(if_a.DONE), 64'd0);
    chk("rst_sclk", 64'(if_a.SER_CLK), 64'd0);
    chk("rst_sdata", 64'(if_a.SER_DATA), 64'd0);

    // Single frame 1011
    push_a(4'b1011);
    if_a.DATA_IN = 4'b1011;
    if_a.START = 1;
    k = cyc;
    @(negedge clk);
    if_a.START = 0;
    if_a.DATA_IN = 4'b0000;
    t0 = cyc;
    chk("single_busy_rise", 64'(if_a.BUSY), 64'd1);
    wait_done(0, 100, t1);
    chk("single_frame_len", 64'(t1 - t0), 64'd16);
    chk("single_latency", 64'(a_first_rise - k), 64'd3);
    chk("single_busy_done", 64'(if_a.BUSY), 64'd0);
    chk("single_sclk_done", 64'(if_a.SER_CLK), 64'd0);
    @(negedge clk);
    chk("single_done_pulse", 64'(if_a.DONE), 64'd0);
    chk("single_q_empty", 64'(a_q.size()), 64'd0);
    repeat (3) @(negedge clk);

    // AUTO refresh: F then 0
    push_a(4'hF);
    push_a(4'h0);
    if_a.AUTO = 1;
    if_a.DATA_IN = 4'hF;
    if_a.START = 1;
    @(negedge clk);
    if_a.START = 0;
    nd = 0;
    drop = 0;
    for (int i = 0; i < 200 && nd < 2; i++) begin
      @(negedge clk);
      if (i == 5) if_a.DATA_IN = 4'h0;
      if (if_a.DONE) begin
        nd++;
        if_a.AUTO = 0;
      end
      if (nd < 2 && !if_a.BUSY) drop++;
    end
    chk("auto_dones", 64'(nd), 64'd2);
    chk("auto_busy_drop", 64'(drop), 64'd0);
    chk("auto_q_empty", 64'(a_q.size()), 64'd0);
    repeat (3) @(negedge clk);

    // START held high for 30 cycles
    push_a(4'b0110);
    push_a(4'b0110);
    if_a.DATA_IN = 4'b0110;
    if_a.START = 1;
    nd = 0;
    pd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (pd) chk("hold_restart_busy", 64'(if_a.BUSY), 64'd1);
      if (if_a.DONE) begin
        chk("hold_done_busy", 64'(if_a.BUSY), 64'd0);
        nd++;
      end
      pd = if_a.DONE;
    end
    if_a.START = 0;
    chk("hold_dones", 64'(nd), 64'd1);
    wait_done(0, 100, t1);
    repeat (10) @(negedge clk);
    chk("hold_idle", 64'(if_a.BUSY), 64'd0);
    chk("hold_q_empty", 64'(a_q.size()), 64'd0);

    // Loopback into receiver models, DIV=1
    v20 = 20'hA5C3E;
    if_l20.DATA_IN = v20;
    if_l20.START = 1;
    @(negedge clk);
    if_l20.START = 0;
    if_l20.DATA_IN = '0;
    wait_done(1, 200, t1);
    chk("l20_rx", 64'(rx20), 64'(v20));
    chk("l20_wrap", 64'(rx20_i), 64'd0);

    v40 = 40'hA5C3E_5A3C1;
    if_l40.DATA_IN = v40;
    if_l40.START = 1;
    @(negedge clk);
    if_l40.START = 0;
    if_l40.DATA_IN = '0;
    wait_done(2, 300, t1);
    chk("l40_rx", 64'(rx40), 64'(v40));
    chk("l40_wrap", 64'(rx40_i), 64'd0);

    // DIV=1 corner
    for (int i = 0; i < 4; i++) d_q.push_back(i[0] ? 1'b0 : 1'b1);
    if_d.DATA_IN = 4'b0101;
    if_d.START = 1;
    @(negedge clk);
    if_d.START = 0;
    wait_done(3, 50, t1);
    chk("d_rises", 64'(d_rises), 64'd4);
    chk("d_stable_at_rise", 64'(d_stab_viol), 64'd0);
    chk("d_toggle", 64'(d_tog_viol), 64'd0);
    chk("d_q_empty", 64'(d_q.size()), 64'd0);

    // Reset during HIGH of bit 2
    push_a(4'b1111);
    void'(a_q.pop_back());
    if_a.DATA_IN = 4'b1111;
    if_a.START = 1;
    @(negedge clk);
    if_a.START = 0;
    nr = 0;
    pc = if_a.SER_CLK;
    for (int i = 0; i < 100 && nr < 3; i++) begin
      @(negedge clk);
      if (if_a.SER_CLK && !pc) nr++;
      pc = if_a.SER_CLK;
    end
    chk("mid_rises", 64'(nr), 64'd3);
    chk("mid_in_high", 64'(if_a.SER_CLK), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_sclk", 64'(if_a.SER_CLK), 64'd0);
    chk("mid_rst_sdata", 64'(if_a.SER_DATA), 64'd0);
    chk("mid_rst_busy", 64'(if_a.BUSY), 64'd0);
    chk("mid_rst_done", 64'(if_a.DONE), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    snap = a_rises;
    repeat (30) @(negedge clk);
    chk("post_rst_rises", 64'(a_rises - snap), 64'd0);
    chk("post_rst_busy", 64'(if_a.BUSY), 64'd0);

    chk("a_extra_edges", 64'(a_extra), 64'd0);
    chk("a_q_final", 64'(a_q.size()), 64'd0);
    chk("d_extra_edges", 64'(d_extra), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
